// File: rtl/sevenseg_scan.sv
// Purpose: multiplexing scan controller feeding a 4-digit seven-segment driver.
// Latency: registered outputs, one cycle behind the internal scan state.
// Backpressure: none; load is a strobe, ack pulses when a pending value goes live at a frame boundary.
//
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   enable         - 1 = scan, 0 = display off (returns to slot 0)
//   load           - strobe capturing value/dpmask as the pending frame
//   value, dpmask  - nibble i / bit i shown on slot i (AN i)
//   lzs            - leading-zero suppression, sampled every cycle
//   ack            - one-cycle pulse when the pending frame becomes active
//   data           - driver code (0-15 hex, 31 = off)
//   digit          - driver select (0 = off, 1-4 = AN0-AN3)
//   setdp          - decimal point request
module sevenseg_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dpmask,
  input  logic        lzs,
  output logic        ack,
  output logic [4:0]  data,
  output logic [2:0]  digit,
  output logic        setdp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } frame_t;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      slot, slot_nxt;
  frame_t          active, pending;
  logic            pend_flag;
  logic            boundary;
  logic            in_guard;
  logic [15:0]     upper;
  logic            suppress;
  logic [4:0]      data_nxt;
  logic [2:0]      digit_nxt;
  logic            setdp_nxt;

  // With no guard interval the comparison would be constant, so it is
  // elaborated away entirely.
  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
      assign in_guard = (cnt < GUARD_C);
    end else begin : g_noguard
      assign in_guard = 1'b0;
    end
  endgenerate

  // Scan sequencing. A frame boundary is either the IDLE->SCAN start or the
  // last cycle of slot 3; only there may the pending frame become active.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    slot_nxt  = slot;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        slot_nxt = '0;
        if (enable) begin
          state_nxt = SCAN;
          boundary  = 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          slot_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          slot_nxt = slot + 2'd1;
          boundary = (slot == 2'd3);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        slot_nxt  = '0;
      end
    endcase
  end

  // Output decode from the current scan position. `upper` holds nibbles
  // slot..3 in its low bits: its low nibble is the digit to show, and if the
  // whole thing is zero the digit is a leading zero.
  always_comb begin
    data_nxt  = 5'd31;
    digit_nxt = '0;
    setdp_nxt = 1'b0;
    upper     = active.val >> {slot, 2'b00};
    suppress  = lzs && (slot != 2'd0) && (upper == 16'd0);
    if (state == SCAN && !in_guard) begin
      digit_nxt = {1'b0, slot} + 3'd1;
      setdp_nxt = active.dp[slot];
      data_nxt  = suppress ? 5'd31 : {1'b0, upper[3:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      slot      <= '0;
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
      ack       <= 1'b0;
      data      <= 5'd31;
      digit     <= '0;
      setdp     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      slot  <= slot_nxt;
      ack   <= boundary && pend_flag;
      if (boundary && pend_flag) begin
        active <= pending;
      end
      // A load coinciding with a boundary transfers the old pending frame
      // above and leaves the new one pending for the next boundary.
      if (load) begin
        pending   <= '{val: value, dp: dpmask};
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
      data  <= data_nxt;
      digit <= digit_nxt;
      setdp <= setdp_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;

  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FRAME = 4 * RD;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dpmask;
  logic        lzs;
  logic        ack;
  logic [4:0]  data;
  logic [2:0]  digit;
  logic        setdp;

  int passes;
  int checks;

  // Reference model: frame position 0..FRAME-1 instead of slot/count.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [15:0] m_pval;
  logic [3:0]  m_pdp;
  bit          m_pf;
  // Expected outputs after the next edge: {ack, data, digit, setdp}
  logic [9:0]  exp;

  sevenseg_scan #(.REFRESH_DIV(RD), .GUARD(G)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .value  (value),
    .dpmask (dpmask),
    .lzs    (lzs),
    .ack    (ack),
    .data   (data),
    .digit  (digit),
    .setdp  (setdp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compute what the DUT should show after the coming edge from the current
  // inputs and model state, advance the model, then step past the edge.
  task automatic tick();
    logic [4:0]  d;
    logic [2:0]  g;
    logic        s;
    logic        a;
    logic [15:0] hi;
    int          sl;
    bit          bnd;
    a = 1'b0; d = 5'd31; g = 3'd0; s = 1'b0; bnd = 1'b0;
    if (!reset) begin
      bnd = enable && (!m_on || m_pos == FRAME - 1);
      a = bnd && m_pf;
      if (m_on && (m_pos % RD) >= G) begin
        sl = m_pos / RD;
        hi = m_val >> (4 * sl);
        g  = 3'(sl + 1);
        s  = m_dp[sl];
        d  = (lzs && sl > 0 && hi == 16'd0) ? 5'd31 : {1'b0, hi[3:0]};
      end
    end
    exp = {a, d, g, s};
    if (reset) begin
      m_on = 0; m_pos = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pf = 0;
    end else begin
      if (bnd && m_pf) begin
        m_val = m_pval; m_dp = m_pdp; m_pf = 0;
      end
      if (load) begin
        m_pval = value; m_pdp = dpmask; m_pf = 1;
      end
      if (!enable) begin
        m_on = 0; m_pos = 0;
      end else if (!m_on) begin
        m_on = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); load = 1'($urandom); lzs = 1'($urandom);
      value = 16'($urandom); dpmask = 4'($urandom);
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== {1'b0, 5'd31, 3'd0, 1'b0})
        $display("FAIL reset_hold: got ack=%b data=%0d digit=%0d dp=%b, want ack=0 data=31 digit=0 dp=0",
                 ack, data, digit, setdp);
      else passes++;
    end
    reset = 1'b0; enable = 1'b0; load = 1'b0; lzs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== {1'b0, 5'd31, 3'd0, 1'b0})
        $display("FAIL reset_idle: got ack=%b data=%0d digit=%0d dp=%b, want ack=0 data=31 digit=0 dp=0",
                 ack, data, digit, setdp);
      else passes++;
    end
  endtask

  task automatic test_scan();
    int acks = 0;
    int first_lit = -1;
    int ack_at = -1;
    logic [4:0] seen [1:4];
    logic [3:0] dpseen = '0;
    for (int k = 1; k <= 4; k++) seen[k] = 5'd30;
    value = 16'h1234; dpmask = 4'b0100; lzs = 1'b0; load = 1'b1;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL scan_cycle %0d: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 i, ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
      if (ack) begin acks++; if (ack_at < 0) ack_at = i; end
      if (digit != 0) begin
        if (first_lit < 0) first_lit = i;
        if (digit <= 4) begin
          seen[digit] = data;
          if (setdp) dpseen[digit-1] = 1'b1;
        end
      end
    end
    checks++;
    if (acks !== 1) $display("FAIL scan_ack_count: got %0d, want 1", acks); else passes++;
    checks++;
    if (ack_at !== 0) $display("FAIL scan_ack_latency: got %0d, want 0", ack_at); else passes++;
    checks++;
    if (first_lit !== G + 1) $display("FAIL scan_first_lit: got %0d, want %0d", first_lit, G + 1); else passes++;
    checks++;
    if ({seen[1], seen[2], seen[3], seen[4]} !== {5'd4, 5'd3, 5'd2, 5'd1})
      $display("FAIL scan_digits: got %0d %0d %0d %0d, want 4 3 2 1", seen[1], seen[2], seen[3], seen[4]);
    else passes++;
    checks++;
    if (dpseen !== 4'b0100) $display("FAIL scan_dp: got %b, want 0100", dpseen); else passes++;
  endtask

  task automatic lzs_case(input logic [15:0] v, input logic [19:0] want);
    bit got_ack = 0;
    logic [4:0] seen [1:4];
    for (int k = 1; k <= 4; k++) seen[k] = 5'd30;
    lzs = 1'b1; value = v; dpmask = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < FRAME + 4 && !got_ack; i++) begin
      got_ack = exp[9];
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL lzs_wait: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
    end
    checks++;
    if (!got_ack) $display("FAIL lzs_ack_timeout: got no boundary, want one within a frame"); else passes++;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL lzs_cycle: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
      if (digit >= 1 && digit <= 4) seen[digit] = data;
    end
    checks++;
    if ({seen[1], seen[2], seen[3], seen[4]} !== want)
      $display("FAIL lzs_digits %h: got %0d %0d %0d %0d, want %0d %0d %0d %0d", v,
               seen[1], seen[2], seen[3], seen[4], want[19:15], want[14:10], want[9:5], want[4:0]);
    else passes++;
  endtask

  task automatic test_lzs();
    lzs_case(16'h0050, {5'd0, 5'd5, 5'd31, 5'd31});
    lzs_case(16'h0000, {5'd0, 5'd31, 5'd31, 5'd31});
    lzs = 1'b0;
  endtask

  task automatic test_latest_wins();
    int acks = 0;
    bit after = 0;
    logic [4:0] seen [1:4];
    for (int k = 1; k <= 4; k++) seen[k] = 5'd30;
    for (int i = 0; i < FRAME + 2 && m_pos != RD; i++) tick();
    load = 1'b1; value = 16'hAAAA; dpmask = 4'b0000;
    tick();
    value = 16'hBBBB;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL latest_cycle %0d: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 i, ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
      if (ack) begin acks++; after = 1; end
      else if (after && digit >= 1 && digit <= 4) seen[digit] = data;
    end
    checks++;
    if (acks !== 1) $display("FAIL latest_ack_count: got %0d, want 1", acks); else passes++;
    checks++;
    if ({seen[1], seen[2], seen[3], seen[4]} !== {4{5'd11}})
      $display("FAIL latest_digits: got %0d %0d %0d %0d, want 11 11 11 11", seen[1], seen[2], seen[3], seen[4]);
    else passes++;
  endtask

  task automatic test_enable_drop();
    int first_lit = -1;
    for (int i = 0; i < FRAME + 2 && m_pos != 2 * RD + 4; i++) tick();
    enable = 1'b0;
    tick();
    tick();
    checks++;
    if ({digit, data} !== {3'd0, 5'd31})
      $display("FAIL drop_blank: got digit=%0d data=%0d, want digit=0 data=31", digit, data);
    else passes++;
    tick();
    enable = 1'b1;
    for (int i = 0; i < RD + 2; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL reenable_cycle %0d: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 i, ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
      if (digit != 0 && first_lit < 0) begin
        first_lit = i;
        checks++;
        if (digit !== 3'd1) $display("FAIL reenable_slot: got digit=%0d, want 1", digit); else passes++;
      end
    end
    checks++;
    if (first_lit !== G + 1) $display("FAIL reenable_guard: got %0d, want %0d", first_lit, G + 1); else passes++;
  endtask

  task automatic test_reset_discard();
    int acks = 0;
    logic [4:0] seen [1:4];
    for (int k = 1; k <= 4; k++) seen[k] = 5'd30;
    enable = 1'b0; lzs = 1'b0;
    tick();
    load = 1'b1; value = 16'h9999; dpmask = 4'b1111;
    tick();
    load = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if ({ack, data, digit, setdp} !== {1'b0, 5'd31, 3'd0, 1'b0})
      $display("FAIL discard_reset: got ack=%b data=%0d digit=%0d dp=%b, want ack=0 data=31 digit=0 dp=0",
               ack, data, digit, setdp);
    else passes++;
    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL discard_cycle %0d: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 i, ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
      if (ack) acks++;
      if (digit >= 1 && digit <= 4) seen[digit] = data;
    end
    checks++;
    if (acks !== 0) $display("FAIL discard_ack: got %0d, want 0", acks); else passes++;
    checks++;
    if ({seen[1], seen[2], seen[3], seen[4]} !== {4{5'd0}})
      $display("FAIL discard_digits: got %0d %0d %0d %0d, want 0 0 0 0", seen[1], seen[2], seen[3], seen[4]);
    else passes++;
  endtask

  task automatic test_random();
    logic [15:0] masks [4];
    masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h000F; masks[3] = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      load   = ($urandom_range(0, 19) == 0);
      value  = 16'($urandom) & masks[$urandom_range(0, 3)];
      dpmask = 4'($urandom);
      if ($urandom_range(0, 49) == 0) lzs = ~lzs;
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      reset  = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if ({ack, data, digit, setdp} !== exp)
        $display("FAIL random_cycle %0d: got ack=%b data=%0d digit=%0d dp=%b, want ack=%b data=%0d digit=%0d dp=%b",
                 i, ack, data, digit, setdp, exp[9], exp[8:4], exp[3:1], exp[0]);
      else passes++;
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    passes = 0; checks = 0;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dpmask = '0; lzs = 1'b0;
    m_on = 0; m_pos = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pf = 0;
    exp = '0;
    test_reset();
    test_scan();
    test_lzs();
    test_latest_wins();
    test_enable_drop();
    test_reset_discard();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Multiplexing scan controller that drives the `sevensegment` display driver. Holds a 4-digit hex value with per-digit decimal points and time-multiplexes it onto the driver's `data`/`digit`/`setdp` inputs, one anode slot at a time. Includes a guard blanking interval per slot, optional leading-zero suppression, and a load/ack handshake that applies new values only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2 and > `GUARD`.
- `GUARD`, 4: blanked cycles at the start of each slot (`digit`=0); 0 allowed.

- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = scan; 0 = display off.
- `load`  in  1  one-cycle strobe; captures `value`/`dpmask` into the pending register.
- `value`  in  16  nibble i (`value[4i+3:4i]`) is shown on digit slot i (AN i).
- `dpmask`  in  4  bit i lights the decimal point on slot i.
- `lzs`  in  1  leading-zero suppression enable; sampled every cycle.
- `ack`  out  1  one-cycle pulse when a pending value becomes active.
- `data`  out  5  code to the driver (0–15 hex, 31 = all off).
- `digit`  out  3  driver digit select (0 = all off, 1–4 = AN0–AN3).
- `setdp`  out  1  decimal point request to the driver.

## Operation
- Internal registers: `active` (16+4 bits), `pending` (16+4 bits), `pend_flag`, `slot` (0–3), `cnt` (0..`REFRESH_DIV`-1), `state` ∈ {IDLE, SCAN}.
- IDLE: `cnt`=0, `slot`=0. When `enable`=1 is sampled: go to SCAN; this cycle is a frame boundary.
- SCAN: `cnt` increments each cycle. At `cnt`=`REFRESH_DIV`-1: `cnt`←0, `slot`←`slot`+1 mod 4. Wrap 3→0 is a frame boundary. `enable`=0 sampled in SCAN: go to IDLE immediately, even mid-slot.
- Frame boundary: if `pend_flag`=1, then `active`←`pending`, `pend_flag`←0, and `ack` pulses for one cycle. Otherwise nothing happens.
- `load`=1: `pending`←{`value`,`dpmask`}, `pend_flag`←1. A new load overwrites an unapplied pending value (latest wins). Multiple loads before a boundary produce exactly one `ack`.
- `load` in the same cycle as a boundary: the previously pending value is transferred; the new load becomes pending and is applied at the next boundary. If nothing was pending, there is no transfer and no `ack` in that cycle.
- Output decode from (`state`, `slot`, `cnt`, `active`, `lzs`):
  - IDLE, or `cnt` < `GUARD`: `digit`=0, `data`=31, `setdp`=0.
  - Otherwise: `digit`=`slot`+1, `data`=nibble[`slot`], `setdp`=`dpmask`[`slot`].
- Leading-zero suppression: with `lzs`=1, slot i (i≥1) shows `data`=31 if nibbles i..3 are all zero. Slot 0 is never suppressed. `setdp` still follows `dpmask` on suppressed slots.
- Transfers to `active` occur only at boundaries, never mid-frame.

## Timing
- `data`, `digit`, `setdp`, `ack` are registered and lag the internal state by one cycle. Posedge-registered outputs are stable at the driver's negedge sample.
- Reset values: `data`=31, `digit`=0, `setdp`=0, `ack`=0. Internally `active`=0, `pending`=0, `pend_flag`=0, `state`=IDLE, `slot`=0, `cnt`=0.
- Reset mid-frame discards the pending value with no `ack`; outputs return to reset values on the next edge.
- Slot length = `REFRESH_DIV` cycles, of which `GUARD` cycles are blanked. Frame length = 4·`REFRESH_DIV` cycles.
- On `enable` rise: `ack` (if pending) appears 1 cycle after `enable` is sampled high. The first lit cycle is `GUARD`+1 cycles after that sample.
- On `enable` fall: the cycle after it is sampled low shows `digit`=0, `data`=31. Re-enable restarts at slot 0 guard.
- Load-to-display worst case ≈ one full frame plus `GUARD`+1 cycles.

## Test plan
- Reset: hold `reset` 3 cycles with random inputs → `data`=31, `digit`=0, `setdp`=0, `ack`=0 throughout. After release with `enable`=0, outputs stay at these values.
- `REFRESH_DIV`=8, `GUARD`=2. Load `value`=16'h1234, `dpmask`=4'b0100, `lzs`=0, then raise `enable` → one `ack`. Per slot: 2 cycles `digit`=0, then 6 cycles of digit 1/data 4, digit 2/data 3, digit 3/data 2 with `setdp`=1, digit 4/data 1. Period is 32 cycles.
- `lzs`=1 with `value`=16'h0050 → digits 4 and 3 show `data`=31, digit 2 shows 5, digit 1 shows 0. With `value`=16'h0000 → only digit 1 shows 0.
- During a frame, load 16'hAAAA then 16'hBBBB → display unchanged until the wrap 3→0. Then exactly one `ack` and all digits show 11 (b).
- Drop `enable` in mid-slot 2 → next cycle `digit`=0, `data`=31. Re-enable → restart at slot 0 with a 2-cycle guard.
- Load, then assert `reset` before the boundary → no `ack`. After re-enable, the display shows 0000.
